// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
//   ADDR_LEN / DATA_LEN : default register address / write data widths
//   MAX_NREQ            : largest supported requester count
//   oh_to_idx()         : one-hot (zero-padded to MAX_NREQ) to binary index
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_LEN = 5;
  localparam int unsigned DATA_LEN = 32;
  localparam int unsigned MAX_NREQ = 8;

  function automatic int unsigned oh_to_idx(input logic [MAX_NREQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the two registered RAM write ports.
//   req_valid/req_addr/req_data : requester side, flattened per requester
//   req_ready                   : combinational grant back to requesters
//   we1/waddr1/wdata1, we2/...  : registered RAM write ports 1 and 2
// modport slave is the arbiter; modport master is the requester/RAM side.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = ADDR_LEN,
  parameter int unsigned DATA_W = DATA_LEN
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   we1;
  logic                   we2;
  logic [ADDR_W-1:0]      waddr1;
  logic [ADDR_W-1:0]      waddr2;
  logic [DATA_W-1:0]      wdata1;
  logic [DATA_W-1:0]      wdata2;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we1, we2, waddr1, waddr2, wdata1, wdata2
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we1, we2, waddr1, waddr2, wdata1, wdata2
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: one-hot of the first set bit of req at or after ptr,
// scanning upward and wrapping modulo NREQ.
//   req    : candidate mask
//   ptr    : scan start index
//   onehot : selected candidate (all zero if none)
//   found  : some candidate was selected
module regfile_wb_arbiter_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic             found
);

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[PTR_W'((32'(ptr) + k) % NREQ)]) begin
        onehot[PTR_W'((32'(ptr) + k) % NREQ)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 2-write-port register file. Up to two requests per
// cycle are granted in round-robin order and registered onto RAM ports 1/2.
// Writes to x0 are acknowledged without using a slot or a RAM write.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : kill this cycle's grants; next cycle issues no write
//   bus          : request bus and RAM write ports (slave side)
//   grant_cnt    : number of non-x0 writes issued, wrapping
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = ADDR_LEN,
  parameter int unsigned DATA_W = DATA_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  regfile_wb_arbiter_if.slave  bus,
  output logic [31:0]          grant_cnt
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDR_W-1:0] addr [NREQ];
  logic [DATA_W-1:0] data [NREQ];
  logic [NREQ-1:0]   x0, same, cand1, cand2, oh1, oh2;
  logic              found1, found2, grant1, grant2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [DATA_W-1:0] data1, data2;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              we1_q, we2_q;
  logic [ADDR_W-1:0] waddr1_q, waddr2_q;
  logic [DATA_W-1:0] wdata1_q, wdata2_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign addr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data[g] = bus.req_data[g*DATA_W +: DATA_W];
    assign x0[g]   = bus.req_valid[g] && (addr[g] == '0);
    assign same[g] = (addr[g] == addr1);
  end

  assign cand1 = bus.req_valid & ~x0;

  regfile_wb_arbiter_rr_pick #(.NREQ(NREQ)) u_pick1 (
    .req    (cand1),
    .ptr    (rr_ptr_q),
    .onehot (oh1),
    .found  (found1)
  );

  // Slot 2 scans from the same pointer; dropping slot 1 and every request
  // aimed at slot 1's address keeps one address to one port per cycle.
  assign cand2 = cand1 & ~oh1 & ~same;

  regfile_wb_arbiter_rr_pick #(.NREQ(NREQ)) u_pick2 (
    .req    (cand2),
    .ptr    (rr_ptr_q),
    .onehot (oh2),
    .found  (found2)
  );

  always_comb begin
    addr1 = '0;
    data1 = '0;
    addr2 = '0;
    data2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (oh1[i]) begin
        addr1 = addr[i];
        data1 = data[i];
      end
      if (oh2[i]) begin
        addr2 = addr[i];
        data2 = data[i];
      end
    end
  end

  assign grant1 = found1 && !flush;
  assign grant2 = found2 && !flush;

  assign bus.req_ready = (oh1 | oh2 | x0) & {NREQ{!flush && reset_n}};

  // Slot 2 always lies after slot 1 in scan order, so it is the last grant.
  always_comb begin
    logic [MAX_NREQ-1:0] last_oh;
    last_oh  = '0;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q + 32'(grant1) + 32'(grant2);
    if (grant1) begin
      last_oh[NREQ-1:0] = found2 ? oh2 : oh1;
      rr_ptr_d = PTR_W'((oh_to_idx(last_oh) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
      waddr1_q <= '0;
      waddr2_q <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      we1_q    <= grant1;
      we2_q    <= grant2;
      if (grant1) begin
        waddr1_q <= addr1;
        wdata1_q <= data1;
      end
      if (grant2) begin
        waddr2_q <= addr2;
        wdata2_q <= data2;
      end
    end
  end

  assign bus.we1    = we1_q;
  assign bus.we2    = we2_q;
  assign bus.waddr1 = waddr1_q;
  assign bus.waddr2 = waddr2_q;
  assign bus.wdata1 = wdata1_q;
  assign bus.wdata2 = wdata2_q;
  assign grant_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_four(input logic [3:0] v);
    set_req(0, v[0], 5'd1, 32'hA0);
    set_req(1, v[1], 5'd2, 32'hA1);
    set_req(2, v[2], 5'd3, 32'hA2);
    set_req(3, v[3], 5'd4, 32'hA3);
  endtask

  task automatic test_reset();
    clear_reqs();
    set_four(4'b1111);
    reset_n = 1'b0;
    #12;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
    n_checks++; if ({bus.we1, bus.we2} !== 2'b00) begin n_fail++; $display("FAIL rst_we: got %b want 00", {bus.we1, bus.we2}); end
    n_checks++; if ({bus.waddr1, bus.waddr2, bus.wdata1, bus.wdata2} !== '0) begin n_fail++; $display("FAIL rst_wport: nonzero addr/data"); end
    n_checks++; if (grant_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", grant_cnt); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;
    n_checks++; if (bus.we1 !== 1'b1) begin n_fail++; $display("FAIL mid_we1: got %b want 1", bus.we1); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.we1, bus.we2} !== 2'b00) begin n_fail++; $display("FAIL async_we: got %b want 00", {bus.we1, bus.we2}); end
    n_checks++; if (grant_cnt !== 32'd0) begin n_fail++; $display("FAIL async_cnt: got %0d want 0", grant_cnt); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL async_ready: got %b want 0000", bus.req_ready); end
    @(negedge clk) reset_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0011) begin n_fail++; $display("FAIL post_rst_ptr: got %b want 0011", bus.req_ready); end
    clear_reqs();
    @(posedge clk) #1;
  endtask

  task automatic test_pair();
    @(negedge clk) set_four(4'b1111);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0011) begin n_fail++; $display("FAIL pair_ready0: got %b want 0011", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'd1, 32'hA0}) begin n_fail++; $display("FAIL pair_port1: got %b/%0d/%h want 1/1/a0", bus.we1, bus.waddr1, bus.wdata1); end
    n_checks++; if ({bus.we2, bus.waddr2, bus.wdata2} !== {1'b1, 5'd2, 32'hA1}) begin n_fail++; $display("FAIL pair_port2: got %b/%0d/%h want 1/2/a1", bus.we2, bus.waddr2, bus.wdata2); end
    n_checks++; if (grant_cnt !== 32'd2) begin n_fail++; $display("FAIL pair_cnt0: got %0d want 2", grant_cnt); end
    set_four(4'b1100);
    @(negedge clk) #1;
    n_checks++; if (bus.req_ready !== 4'b1100) begin n_fail++; $display("FAIL pair_ready1: got %b want 1100", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.waddr1, bus.waddr2} !== {5'd3, 5'd4}) begin n_fail++; $display("FAIL pair_addr1: got %0d,%0d want 3,4", bus.waddr1, bus.waddr2); end
    n_checks++; if (grant_cnt !== 32'd4) begin n_fail++; $display("FAIL pair_cnt1: got %0d want 4", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    set_req(0, 1'b1, 5'd5, 32'hAAAA);
    set_req(1, 1'b1, 5'd5, 32'hBBBB);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL same_ready0: got %b want 0001", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1, bus.we2} !== {1'b1, 5'd5, 32'hAAAA, 1'b0}) begin n_fail++; $display("FAIL same_w0: got %b/%0d/%h we2=%b want 1/5/aaaa we2=0", bus.we1, bus.waddr1, bus.wdata1, bus.we2); end
    set_req(0, 1'b0, 5'd0, 32'h0);
    @(negedge clk) #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL same_ready1: got %b want 0010", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1, bus.we2} !== {1'b1, 5'd5, 32'hBBBB, 1'b0}) begin n_fail++; $display("FAIL same_w1: got %b/%0d/%h we2=%b want 1/5/bbbb we2=0", bus.we1, bus.waddr1, bus.wdata1, bus.we2); end
    n_checks++; if (grant_cnt !== 32'd6) begin n_fail++; $display("FAIL same_cnt: got %0d want 6", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_x0();
    @(negedge clk);
    set_req(2, 1'b1, 5'd0, 32'hDEAD);
    set_req(3, 1'b1, 5'd7, 32'h77);
    #1;
    n_checks++; if (bus.req_ready !== 4'b1100) begin n_fail++; $display("FAIL x0_ready: got %b want 1100", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'd7, 32'h77}) begin n_fail++; $display("FAIL x0_port1: got %b/%0d/%h want 1/7/77", bus.we1, bus.waddr1, bus.wdata1); end
    n_checks++; if ({bus.we2, bus.waddr2, bus.wdata2} !== {1'b0, 5'd4, 32'hA3}) begin n_fail++; $display("FAIL x0_port2_hold: got %b/%0d/%h want 0/4/a3", bus.we2, bus.waddr2, bus.wdata2); end
    n_checks++; if (grant_cnt !== 32'd7) begin n_fail++; $display("FAIL x0_cnt: got %0d want 7", grant_cnt); end
    clear_reqs();
    // x0-only cycle must leave the pointer at 0
    @(negedge clk) set_req(1, 1'b1, 5'd0, 32'h1);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL x0only_ready: got %b want 0010", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.we2, grant_cnt} !== {2'b00, 32'd7}) begin n_fail++; $display("FAIL x0only_w: got we=%b%b cnt=%0d want 00 cnt=7", bus.we1, bus.we2, grant_cnt); end
    clear_reqs();
    @(negedge clk);
    set_req(1, 1'b1, 5'd11, 32'h11);
    set_req(2, 1'b1, 5'd12, 32'h12);
    set_req(3, 1'b1, 5'd13, 32'h13);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0110) begin n_fail++; $display("FAIL x0only_ptr: got %b want 0110", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if (grant_cnt !== 32'd9) begin n_fail++; $display("FAIL x0only_cnt: got %0d want 9", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_req(0, 1'b1, 5'd8, 32'h80);
    set_req(1, 1'b1, 5'd9, 32'h90);
    set_req(2, 1'b1, 5'd10, 32'hA0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0011) begin n_fail++; $display("FAIL fl_ready0: got %b want 0011", bus.req_ready); end
    @(posedge clk) #1;
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    set_req(0, 1'b1, 5'd11, 32'hB0);
    set_req(1, 1'b1, 5'd12, 32'hC0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL fl_ready: got %b want 0000", bus.req_ready); end
    n_checks++; if ({bus.we1, bus.waddr1, bus.we2, bus.waddr2} !== {1'b1, 5'd8, 1'b1, 5'd9}) begin n_fail++; $display("FAIL fl_inflight: got %b/%0d %b/%0d want 1/8 1/9", bus.we1, bus.waddr1, bus.we2, bus.waddr2); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.we2} !== 2'b00) begin n_fail++; $display("FAIL fl_we: got %b want 00", {bus.we1, bus.we2}); end
    n_checks++; if (grant_cnt !== 32'd11) begin n_fail++; $display("FAIL fl_cnt: got %0d want 11", grant_cnt); end
    @(negedge clk) flush = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0101) begin n_fail++; $display("FAIL fl_ptr: got %b want 0101", bus.req_ready); end
    @(posedge clk) #1;
    n_checks++; if ({bus.waddr1, bus.wdata1, bus.waddr2, bus.wdata2} !== {5'd10, 32'hA0, 5'd11, 32'hB0}) begin n_fail++; $display("FAIL fl_after: got %0d/%h %0d/%h want 10/a0 11/b0", bus.waddr1, bus.wdata1, bus.waddr2, bus.wdata2); end
    n_checks++; if (grant_cnt !== 32'd13) begin n_fail++; $display("FAIL fl_cnt2: got %0d want 13", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk) set_req(1, 1'b1, 5'd6, 32'h1);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_ready0: got %b want 0010", bus.req_ready); end
    @(posedge clk) #1;
    set_req(1, 1'b1, 5'd6, 32'h2);
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'd6, 32'h1}) begin n_fail++; $display("FAIL b2b_w0: got %b/%0d/%h want 1/6/1", bus.we1, bus.waddr1, bus.wdata1); end
    @(posedge clk) #1;
    n_checks++; if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'd6, 32'h2}) begin n_fail++; $display("FAIL b2b_w1: got %b/%0d/%h want 1/6/2", bus.we1, bus.waddr1, bus.wdata1); end
    n_checks++; if (grant_cnt !== 32'd15) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 15", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_random();
    logic [N-1:0]  v;
    logic [N-1:0]  er;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    int            wt [N];
    int            ptr, s1, s2, ii, bound;
    logic          conflict;
    logic [32:0]   m_p1, m_p2;
    logic [31:0]   m_cnt;
    logic [4:0]    m_a1, m_a2;
    logic [31:0]   m_d1, m_d2;
    logic          m_we1, m_we2;
    bound = (N + 1) / 2;
    v = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; wt[i] = 0; end
    @(negedge clk);
    clear_reqs();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    ptr = 0; m_cnt = 0; m_we1 = 0; m_we2 = 0; m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
        set_req(i, v[i], a[i], d[i]);
      end
      flush = ($urandom_range(0, 9) == 0);
      #1;
      s1 = -1; s2 = -1; er = '0;
      for (int k = 0; k < N; k++) begin
        ii = (ptr + k) % N;
        if (v[ii]) begin
          if (a[ii] == 0) er[ii] = 1'b1;
          else if (s1 < 0) s1 = ii;
          else if (s2 < 0 && a[ii] != a[s1]) s2 = ii;
        end
      end
      if (flush) begin
        er = '0; s1 = -1; s2 = -1;
      end else begin
        if (s1 >= 0) er[s1] = 1'b1;
        if (s2 >= 0) er[s2] = 1'b1;
      end
      n_checks++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.req_ready, er); end
      for (int i = 0; i < N; i++) begin
        if (!flush && v[i] && a[i] != 0) begin
          conflict = 1'b0;
          for (int j = 0; j < N; j++) if (j != i && v[j] && a[j] == a[i]) conflict = 1'b1;
          if (er[i]) begin
            n_checks++; if (wt[i] > bound) begin n_fail++; $display("FAIL rnd_fair c%0d req%0d: waited %0d want <= %0d", cyc, i, wt[i], bound); end
            wt[i] = 0;
          end else if (conflict) wt[i] = 0;
          else wt[i]++;
        end else if (!v[i]) wt[i] = 0;
      end
      @(posedge clk) #1;
      m_we1 = (s1 >= 0);
      m_we2 = (s2 >= 0);
      if (m_we1) begin m_a1 = a[s1]; m_d1 = d[s1]; end
      if (m_we2) begin m_a2 = a[s2]; m_d2 = d[s2]; end
      if (s1 >= 0) ptr = (((s2 >= 0) ? s2 : s1) + 1) % N;
      m_cnt = m_cnt + 32'(m_we1) + 32'(m_we2);
      m_p1 = {m_we1, m_d1};
      m_p2 = {m_we2, m_d2};
      n_checks++; if ({bus.we1, bus.wdata1} !== m_p1 || bus.waddr1 !== m_a1) begin n_fail++; $display("FAIL rnd_port1 c%0d: got %b/%0d/%h want %b/%0d/%h", cyc, bus.we1, bus.waddr1, bus.wdata1, m_we1, m_a1, m_d1); end
      n_checks++; if ({bus.we2, bus.wdata2} !== m_p2 || bus.waddr2 !== m_a2) begin n_fail++; $display("FAIL rnd_port2 c%0d: got %b/%0d/%h want %b/%0d/%h", cyc, bus.we2, bus.waddr2, bus.wdata2, m_we2, m_a2, m_d2); end
      n_checks++; if (grant_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, grant_cnt, m_cnt); end
      for (int i = 0; i < N; i++) if (er[i]) v[i] = 1'b0;
    end
    @(negedge clk);
    flush = 1'b0;
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_pair();
    test_same_addr();
    test_x0();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
